dmem_arbiter: RTL and testbench

Two-requester arbiter in front of the single data port of the unified memory block (byte-masked write, synchronous 1-cycle read). Port 0 is the CPU load/store unit. Port 1 is the secondary master: boot loader, DMA or debug. Port 0 has fixed priority, bounded by a starvation counter that guarantees port 1 progress. Port 1 may also lock the port for bursts. The arbiter drives the memory's `mem_addr/mem_wdata/mem_wmask` and routes the registered `mem_data` back to the port that issued the access.

---
 rtl/dmem_arbiter.sv | 115 +++++++++++
 tb/tb_dmem_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter in front of a single-port data memory.
// Port 0 (load/store unit) has fixed priority. A starvation counter forces
// port 1 through after MAX_WAIT refused cycles. Port 1 may lock the memory
// for bursts. Responses come back one cycle after the grant, to the granted port.
//
// Handshake: a port holds pX_req (and its address/data/mask) until pX_gnt is
// high in the same cycle. That cycle is the accepted access. Exactly one cycle
// later pX_rvalid is high for one cycle with pX_rdata. For a write, this
// response is the acknowledge and carries the pre-write word.
module dmem_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [3:0]  p0_wmask,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [3:0]  p1_wmask,
  input  logic        p1_lock,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_data,
  output logic        dbg_state,
  output logic [7:0]  dbg_wait_cnt
);

  typedef enum logic {
    ARB   = 1'b0,
    LOCK1 = 1'b1
  } state_t;

  localparam logic [7:0] MAX_W = MAX_WAIT[7:0];

  state_t      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        pend_q, pend_d;
  logic        owner_q, owner_d;
  logic        hold_lock;
  logic        force_p1;

  // Grant decision: a live lock keeps port 1; otherwise port 0 wins unless port 1 is starved.
  always_comb begin
    hold_lock = (state_q == LOCK1) && p1_req && p1_lock;
    force_p1  = p1_req && (wait_cnt_q == MAX_W);
    p1_gnt    = p1_req && (hold_lock || force_p1 || !p0_req);
    p0_gnt    = p0_req && !p1_gnt;
  end

  // Memory request mux; with no grant the address idles on port 0 and no byte is written.
  always_comb begin
    mem_addr  = p0_addr;
    mem_wdata = p0_wdata;
    mem_wmask = 4'b0000;
    if (p1_gnt) begin
      mem_addr  = p1_addr;
      mem_wdata = p1_wdata;
      mem_wmask = p1_wmask;
    end else if (p0_gnt) begin
      mem_wmask = p0_wmask;
    end
  end

  // Next-state: lock state, starvation counter and response tracking.
  always_comb begin
    state_d    = ARB;
    wait_cnt_d = wait_cnt_q;
    pend_d     = p0_gnt || p1_gnt;
    owner_d    = p1_gnt;
    if (p1_gnt && p1_lock) begin
      state_d = LOCK1;
    end
    if (!p1_req || p1_gnt) begin
      wait_cnt_d = 8'd0;
    end else if (wait_cnt_q < MAX_W) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  // State register; reset drops any lock and any response still in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ARB;
      wait_cnt_q <= 8'd0;
      pend_q     <= 1'b0;
      owner_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      pend_q     <= pend_d;
      owner_q    <= owner_d;
    end
  end

  // Responses: both ports see the memory word, only the owner gets rvalid.
  always_comb begin
    p0_rvalid    = pend_q && !owner_q;
    p1_rvalid    = pend_q && owner_q;
    p0_rdata     = mem_data;
    p1_rdata     = mem_data;
    dbg_state    = state_q;
    dbg_wait_cnt = wait_cnt_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: memory model, per-scenario tasks, response scoreboard.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        p0_req, p1_req, p1_lock;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic [3:0]  p0_wmask, p1_wmask;
  logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [31:0] p0_rdata, p1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_data;
  logic [3:0]  mem_wmask;
  logic        dbg_state;
  logic [7:0]  dbg_wait_cnt;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] ram    [0:16383];
  logic [31:0] shadow [0:16383];
  logic [32:0] exp_q[$];

  dmem_arbiter #(.MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_wmask(p0_wmask),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_wmask(p1_wmask),
    .p1_lock(p1_lock), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_data(mem_data), .dbg_state(dbg_state), .dbg_wait_cnt(dbg_wait_cnt)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory: synchronous read of the old word, byte-masked write on the same edge.
  always @(posedge clk) begin
    mem_data <= ram[mem_addr[15:2]];
    for (int b = 0; b < 4; b++)
      if (mem_wmask[b]) ram[mem_addr[15:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  function automatic logic [31:0] init_word(input int i);
    return {16'(i) ^ 16'h5A00, ~16'(i)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic [3:0] m0, input logic r1, input logic [31:0] a1,
                       input logic [31:0] d1, input logic [3:0] m1, input logic lk);
    @(posedge clk);
    #1;
    p0_req = r0; p0_addr = a0; p0_wdata = d0; p0_wmask = m0;
    p1_req = r1; p1_addr = a1; p1_wdata = d1; p1_wmask = m1; p1_lock = lk;
    @(negedge clk);
  endtask

  task automatic drive_idle();
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
  endtask

  // Expected response of an accepted access (pre-write word), then apply the write to the model.
  function automatic void push_exp(input logic port, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [3:0] wmask);
    logic [13:0] idx;
    idx = addr[15:2];
    exp_q.push_back({port, shadow[idx]});
    for (int b = 0; b < 4; b++)
      if (wmask[b]) shadow[idx][8*b +: 8] = wdata[8*b +: 8];
  endfunction

  // ---------------- scoreboard ----------------
  initial begin
    logic [32:0] e;
    logic        ev0, ev1;
    logic [31:0] got;
    forever begin
      @(posedge clk);
      #2;
      if (reset) begin
        n_cmp++;
        if ({p0_rvalid, p1_rvalid} !== 2'b00) begin
          n_err++;
          $display("FAIL rvalid_in_reset: got %b expected 00", {p0_rvalid, p1_rvalid});
        end
      end else begin
        ev0 = 1'b0; ev1 = 1'b0; e = '0;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          ev0 = !e[32];
          ev1 = e[32];
        end
        n_cmp++;
        if ({p0_rvalid, p1_rvalid} !== {ev0, ev1}) begin
          n_err++;
          $display("FAIL rvalid @%0t: got %b expected %b", $time, {p0_rvalid, p1_rvalid}, {ev0, ev1});
        end
        if (ev0 || ev1) begin
          got = e[32] ? p1_rdata : p0_rdata;
          n_cmp++;
          if (got !== e[31:0]) begin
            n_err++;
            $display("FAIL rdata_p%0d @%0t: got %h expected %h", e[32], $time, got, e[31:0]);
          end
        end
      end
    end
  end

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({p0_rvalid, p1_rvalid, mem_wmask} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b expected 000000", {p0_rvalid, p1_rvalid, mem_wmask});
    end
    n_cmp++;
    if ({dbg_state, dbg_wait_cnt} !== 9'd0) begin
      n_err++;
      $display("FAIL reset_state: got %h expected 0", {dbg_state, dbg_wait_cnt});
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_read_p0();
    drive(1'b1, 32'h10, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    n_cmp++;
    if ({p0_gnt, p1_gnt, mem_addr, mem_wmask} !== {2'b10, 32'h10, 4'h0}) begin
      n_err++;
      $display("FAIL read_p0_gnt: got %b %b %h %h expected 1 0 10 0", p0_gnt, p1_gnt, mem_addr, mem_wmask);
    end
    push_exp(1'b0, 32'h10, 32'h0, 4'h0);
    drive_idle();
    n_cmp++;
    if ({p0_rvalid, p1_rvalid, p0_rdata} !== {2'b10, init_word(4)}) begin
      n_err++;
      $display("FAIL read_p0_data: got %b %b %h expected 1 0 %h", p0_rvalid, p1_rvalid, p0_rdata, init_word(4));
    end
  endtask

  task automatic test_byte_write_p1();
    logic [31:0] orig;
    orig = init_word(8);
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h20, 32'h0000AB00, 4'b0010, 1'b0);
    n_cmp++;
    if ({p0_gnt, p1_gnt, mem_addr, mem_wdata, mem_wmask} !== {2'b01, 32'h20, 32'h0000AB00, 4'b0010}) begin
      n_err++;
      $display("FAIL write_p1_mux: got %b%b %h %h %b", p0_gnt, p1_gnt, mem_addr, mem_wdata, mem_wmask);
    end
    push_exp(1'b1, 32'h20, 32'h0000AB00, 4'b0010);
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h20, 32'h0, 4'h0, 1'b0);
    n_cmp++;
    if ({p1_gnt, p1_rvalid, p1_rdata} !== {2'b11, orig}) begin
      n_err++;
      $display("FAIL write_ack_p1: got %b %b %h expected 1 1 %h", p1_gnt, p1_rvalid, p1_rdata, orig);
    end
    push_exp(1'b1, 32'h20, 32'h0, 4'h0);
    drive_idle();
    n_cmp++;
    if ({p1_rvalid, p1_rdata} !== {1'b1, (orig & 32'hFFFF00FF) | 32'h0000AB00}) begin
      n_err++;
      $display("FAIL merged_read_p1: got %b %h expected 1 %h", p1_rvalid, p1_rdata,
               (orig & 32'hFFFF00FF) | 32'h0000AB00);
    end
  endtask

  task automatic test_starvation();
    logic [31:0] a0, a1, d0;
    logic [3:0]  m0;
    logic        e1;
    for (int i = 0; i < 10; i++) begin
      a0 = 32'($urandom_range(64, 127)) << 2;
      a1 = 32'($urandom_range(128, 191)) << 2;
      d0 = $urandom;
      m0 = 4'($urandom_range(0, 15));
      drive(1'b1, a0, d0, m0, 1'b1, a1, 32'h0, 4'h0, 1'b0);
      e1 = (i % 5 == 4);
      n_cmp++;
      if ({p0_gnt, p1_gnt} !== {!e1, e1}) begin
        n_err++;
        $display("FAIL starve_gnt cycle %0d: got %b%b expected %b%b", i, p0_gnt, p1_gnt, !e1, e1);
      end
      n_cmp++;
      if (dbg_wait_cnt !== 8'(i % 5)) begin
        n_err++;
        $display("FAIL starve_wait cycle %0d: got %0d expected %0d", i, dbg_wait_cnt, i % 5);
      end
      n_cmp++;
      if (mem_wmask !== (e1 ? 4'h0 : m0)) begin
        n_err++;
        $display("FAIL starve_wmask cycle %0d: got %b expected %b", i, mem_wmask, e1 ? 4'h0 : m0);
      end
      if (e1) push_exp(1'b1, a1, 32'h0, 4'h0);
      else    push_exp(1'b0, a0, d0, m0);
    end
    drive_idle();
  endtask

  task automatic test_lock_burst();
    logic [31:0] a0, a1;
    logic        e1;
    a0 = 32'h400;
    for (int i = 0; i < 12; i++) begin
      a1 = 32'h300 + 32'(4 * i);
      drive(1'b1, a0, 32'h0, 4'h0, 1'b1, a1, 32'h0, 4'h0, 1'b1);
      e1 = (i >= 4);
      n_cmp++;
      if ({p0_gnt, p1_gnt} !== {!e1, e1}) begin
        n_err++;
        $display("FAIL burst_gnt cycle %0d: got %b%b expected %b%b", i, p0_gnt, p1_gnt, !e1, e1);
      end
      if (i >= 5) begin
        n_cmp++;
        if (dbg_state !== 1'b1) begin
          n_err++;
          $display("FAIL burst_state cycle %0d: got %b expected 1", i, dbg_state);
        end
      end
      if (e1) push_exp(1'b1, a1, 32'h0, 4'h0);
      else    push_exp(1'b0, a0, 32'h0, 4'h0);
    end
    drive(1'b1, a0, 32'h0, 4'h0, 1'b1, 32'h340, 32'h0, 4'h0, 1'b0);
    n_cmp++;
    if ({p0_gnt, p1_gnt} !== 2'b10) begin
      n_err++;
      $display("FAIL burst_unlock_gnt: got %b%b expected 10", p0_gnt, p1_gnt);
    end
    push_exp(1'b0, a0, 32'h0, 4'h0);
    drive_idle();
    n_cmp++;
    if (dbg_state !== 1'b0) begin
      n_err++;
      $display("FAIL burst_exit_state: got %b expected 0", dbg_state);
    end
  endtask

  task automatic test_idle();
    logic [31:0] a0;
    for (int i = 0; i < 3; i++) begin
      a0 = $urandom;
      drive(1'b0, a0, $urandom, 4'hF, 1'b0, $urandom, $urandom, 4'hF, 1'b1);
      n_cmp++;
      if ({p0_gnt, p1_gnt, mem_wmask, mem_addr} !== {2'b00, 4'h0, a0}) begin
        n_err++;
        $display("FAIL idle_mux: got %b%b %b %h expected 00 0000 %h", p0_gnt, p1_gnt, mem_wmask, mem_addr, a0);
      end
      n_cmp++;
      if ({dbg_state, dbg_wait_cnt} !== 9'd0) begin
        n_err++;
        $display("FAIL idle_state: got %h expected 0", {dbg_state, dbg_wait_cnt});
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h500 + 32'(4 * i), 32'h0, 4'h0, 1'b1);
      n_cmp++;
      if (p1_gnt !== 1'b1) begin
        n_err++;
        $display("FAIL rst_burst_gnt cycle %0d: got %b expected 1", i, p1_gnt);
      end
      push_exp(1'b1, 32'h500 + 32'(4 * i), 32'h0, 4'h0);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    p1_req = 1'b0; p1_lock = 1'b0;
    #1;
    n_cmp++;
    if ({p0_rvalid, p1_rvalid, dbg_state} !== 3'b000) begin
      n_err++;
      $display("FAIL rst_mid_burst: got %b expected 000", {p0_rvalid, p1_rvalid, dbg_state});
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    p0_req = 1'b1; p0_addr = 32'h40; p0_wdata = 32'h0; p0_wmask = 4'h0;
    @(negedge clk);
    n_cmp++;
    if ({p0_gnt, dbg_state} !== 2'b10) begin
      n_err++;
      $display("FAIL rst_release_gnt: got %b expected 10", {p0_gnt, dbg_state});
    end
    push_exp(1'b0, 32'h40, 32'h0, 4'h0);
    drive_idle();
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    reset = 1'b1;
    p0_req = 1'b0; p0_addr = '0; p0_wdata = '0; p0_wmask = '0;
    p1_req = 1'b0; p1_addr = '0; p1_wdata = '0; p1_wmask = '0; p1_lock = 1'b0;
    mem_data = '0;
    for (int i = 0; i < 16384; i++) begin
      ram[i]    = init_word(i);
      shadow[i] = init_word(i);
    end
    test_reset();
    test_read_p0();
    test_byte_write_p1();
    test_starvation();
    test_lock_burst();
    test_idle();
    test_reset_mid_burst();
    drive_idle();
    drive_idle();
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL drain: got %0d responses outstanding expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
